// File: rtl/gshare_predictor_pkg.sv
// Shared types and constants for the gshare predictor and its helpers.
// Bundle widths are functions so every instantiation derives them from its own parameters.
package gshare_predictor_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [1:0] CNT_INIT = 2'b01;
    localparam logic [1:0] CNT_MAX  = 2'b11;
    localparam logic [1:0] CNT_MIN  = 2'b00;

    // from_FE_to_predictor: fetch PC only
    function automatic int fe_to_pred_w(input int pc_bits);
        return pc_bits;
    endfunction

    // from_predictor_to_FE: {taken, target, idx}
    function automatic int pred_to_fe_w(input int pc_bits, input int idx_bits);
        return 1 + pc_bits + idx_bits;
    endfunction

    // from_AGEX_to_updater: {valid, pc, idx, taken, target}
    function automatic int agex_to_upd_w(input int pc_bits, input int idx_bits);
        return 1 + pc_bits + idx_bits + 1 + pc_bits;
    endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// FE/AGEX-facing bus of the gshare predictor: master is the pipeline, slave is the predictor.
// Predictions are combinational; no backpressure, an update is consumed in the cycle it is valid.
interface gshare_predictor_if #(
    parameter int PC_BITS  = 32,
    parameter int IDX_BITS = 8
);
    logic                ready;
    logic [PC_BITS-1:0]  fe_pc;
    logic                pred_taken;
    logic [PC_BITS-1:0]  pred_target;
    logic [IDX_BITS-1:0] pred_idx;
    logic                upd_valid;
    logic [PC_BITS-1:0]  upd_pc;
    logic [IDX_BITS-1:0] upd_idx;
    logic                upd_taken;
    logic [PC_BITS-1:0]  upd_target;

    modport master (
        input  ready, pred_taken, pred_target, pred_idx,
        output fe_pc, upd_valid, upd_pc, upd_idx, upd_taken, upd_target
    );

    modport slave (
        output ready, pred_taken, pred_target, pred_idx,
        input  fe_pc, upd_valid, upd_pc, upd_idx, upd_taken, upd_target
    );
endinterface

// File: rtl/gshare_predictor_sat_counter_update.sv
// 2-bit saturating counter next-state function, shared by the predictor family.
// Purely combinational; no state, no backpressure.
module sat_counter_update
    import gshare_predictor_pkg::*;
(
    input  logic [1:0] cnt_in,
    input  logic       taken,
    output logic [1:0] cnt_out
);
    always_comb begin
        cnt_out = cnt_in;
        if (taken && (cnt_in != CNT_MAX)) begin
            cnt_out = cnt_in + 2'b01;
        end else if (!taken && (cnt_in != CNT_MIN)) begin
            cnt_out = cnt_in - 2'b01;
        end
    end
endmodule

// File: rtl/gshare_predictor.sv
// gshare direction predictor with direct-mapped BTB; tables are swept clear after reset.
// Prediction is same-cycle from fe_pc; updates land on the next edge; never stalls the pipe.
module gshare_predictor
    import gshare_predictor_pkg::*;
#(
    parameter int PC_BITS   = 32,
    parameter int IDX_BITS  = 8,
    parameter int HIST_BITS = 8   // 1 <= HIST_BITS <= IDX_BITS
) (
    input  logic              clk,
    input  logic              reset,
    gshare_predictor_if.slave bus
);
    localparam int ENTRIES  = 1 << IDX_BITS;
    localparam int TAG_BITS = PC_BITS - IDX_BITS - 2;

    typedef struct packed {
        logic                vld;
        logic [TAG_BITS-1:0] tag;
        logic [PC_BITS-1:0]  target;
    } btb_entry_t;

    // Storage: async read, single write port, no reset so it maps to distributed RAM
    logic [1:0] pht_q [ENTRIES];
    btb_entry_t btb_q [ENTRIES];

    state_e               state_q, state_d;
    logic [IDX_BITS-1:0]  sweep_q, sweep_d;
    logic                 ready_q, ready_d;
    logic [HIST_BITS-1:0] ghr_q, ghr_d;

    logic                pht_we;
    logic [IDX_BITS-1:0] pht_waddr;
    logic [1:0]          pht_wdata;
    logic                btb_we;
    logic [IDX_BITS-1:0] btb_waddr;
    btb_entry_t          btb_wdata;

    logic [IDX_BITS-1:0] fe_bidx;
    logic [IDX_BITS-1:0] upd_bidx;
    btb_entry_t          fe_entry;
    logic                btb_hit;
    logic [1:0]          pht_rd;
    logic [1:0]          pht_upd_cnt;
    logic [1:0]          pht_upd_nxt;

    assign fe_bidx  = bus.fe_pc[IDX_BITS+1:2];
    assign upd_bidx = bus.upd_pc[IDX_BITS+1:2];

    // Prediction path
    assign fe_entry       = btb_q[fe_bidx];
    assign btb_hit        = fe_entry.vld && (fe_entry.tag == bus.fe_pc[PC_BITS-1:IDX_BITS+2]);
    assign bus.pred_idx   = fe_bidx ^ IDX_BITS'(ghr_q);
    assign pht_rd         = pht_q[bus.pred_idx];
    assign bus.pred_taken = (state_q == ST_RUN) && btb_hit && pht_rd[1];
    assign bus.pred_target = bus.pred_taken ? fe_entry.target : (bus.fe_pc + PC_BITS'(4));
    assign bus.ready      = ready_q;

    assign pht_upd_cnt = pht_q[bus.upd_idx];

    sat_counter_update u_sat (
        .cnt_in  (pht_upd_cnt),
        .taken   (bus.upd_taken),
        .cnt_out (pht_upd_nxt)
    );

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        ready_d = ready_q;
        ghr_d   = ghr_q;
        case (state_q)
            ST_INIT: begin
                sweep_d = sweep_q + IDX_BITS'(1);
                if (&sweep_q) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                // Width cast drops the oldest bit, which also covers HIST_BITS == 1
                if (bus.upd_valid) begin
                    ghr_d = HIST_BITS'({ghr_q, bus.upd_taken});
                end
            end
            default: begin
                state_d = ST_INIT;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
            ready_q <= 1'b0;
            ghr_q   <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            ready_q <= ready_d;
            ghr_q   <= ghr_d;
        end
    end

    // Write-port muxing: the sweep owns both tables until RUN
    always_comb begin
        pht_we    = 1'b0;
        pht_waddr = sweep_q;
        pht_wdata = CNT_INIT;
        btb_we    = 1'b0;
        btb_waddr = sweep_q;
        btb_wdata = '0;
        if (!reset) begin
            if (state_q == ST_INIT) begin
                pht_we = 1'b1;
                btb_we = 1'b1;
            end else if (bus.upd_valid) begin
                pht_we    = 1'b1;
                pht_waddr = bus.upd_idx;
                pht_wdata = pht_upd_nxt;
                if (bus.upd_taken) begin
                    btb_we    = 1'b1;
                    btb_waddr = upd_bidx;
                    btb_wdata = '{vld: 1'b1,
                                  tag: bus.upd_pc[PC_BITS-1:IDX_BITS+2],
                                  target: bus.upd_target};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pht_we) begin
            pht_q[pht_waddr] <= pht_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (btb_we) begin
            btb_q[btb_waddr] <= btb_wdata;
        end
    end

    // Alignment bits and the counter's low bit carry no prediction information
    logic unused_ok;
    assign unused_ok = ^{bus.fe_pc[1:0], bus.upd_pc[1:0], pht_rd[0]};

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor at IDX_BITS=4, HIST_BITS=4.
module tb_gshare_predictor;

    logic clk;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    gshare_predictor_if #(.PC_BITS(32), .IDX_BITS(4)) bus ();

    gshare_predictor #(.PC_BITS(32), .IDX_BITS(4), .HIST_BITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        upd_v;
        logic [31:0] upd_pc;
        logic [3:0]  upd_idx;
        logic        upd_taken;
        logic [31:0] upd_tgt;
        logic        exp_taken;
        logic [31:0] exp_tgt;
        logic [3:0]  exp_idx;
    } vec_t;

    typedef struct {
        logic        taken;
        logic [31:0] tgt;
        logic [3:0]  idx;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    function automatic vec_t mk(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                                input logic [3:0] uidx, input logic ut, input logic [31:0] utgt,
                                input logic et, input logic [31:0] etgt, input logic [3:0] eidx);
        vec_t v;
        v.pc = pc; v.upd_v = uv; v.upd_pc = upc; v.upd_idx = uidx;
        v.upd_taken = ut; v.upd_tgt = utgt;
        v.exp_taken = et; v.exp_tgt = etgt; v.exp_idx = eidx;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;

        reset          = 1'b1;
        bus.fe_pc      = 32'h100;
        bus.upd_valid  = 1'b0;
        bus.upd_pc     = 32'h0;
        bus.upd_idx    = 4'h0;
        bus.upd_taken  = 1'b0;
        bus.upd_target = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset ready", 32'(bus.ready), 32'd0);
        next_cycle();

        // First sweep, interrupted by reset at cycle 7
        reset = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check($sformatf("sweep1 c%0d ready", c), 32'(bus.ready), 32'd0);
            check($sformatf("sweep1 c%0d taken", c), 32'(bus.pred_taken), 32'd0);
            next_cycle();
        end
        reset = 1'b1;
        @(negedge clk);
        check("midinit reset ready", 32'(bus.ready), 32'd0);
        next_cycle();
        reset = 1'b0;

        // Full 16-cycle sweep; updates offered during INIT must be ignored
        for (int c = 0; c <= 16; c++) begin
            bus.upd_valid  = (c < 16);
            bus.upd_pc     = 32'h100;
            bus.upd_idx    = 4'h0;
            bus.upd_taken  = 1'b1;
            bus.upd_target = 32'h200;
            @(negedge clk);
            check($sformatf("sweep2 c%0d ready", c), 32'(bus.ready), (c == 16) ? 32'd1 : 32'd0);
            check($sformatf("sweep2 c%0d taken", c), 32'(bus.pred_taken), 32'd0);
            check($sformatf("sweep2 c%0d target", c), bus.pred_target, 32'h104);
            next_cycle();
        end
        bus.upd_valid = 1'b0;

        // Cold miss, training, GHR rewind, saturation, alias and same-cycle update
        vecs.push_back(mk(32'h100, 0, 32'h0,    4'h0, 0, 32'h0,   0, 32'h104, 4'h0));
        vecs.push_back(mk(32'h100, 1, 32'h100,  4'h0, 1, 32'h200, 0, 32'h104, 4'h0));
        vecs.push_back(mk(32'h100, 1, 32'h100,  4'h0, 1, 32'h200, 0, 32'h104, 4'h1));
        vecs.push_back(mk(32'h10C, 0, 32'h0,    4'h0, 0, 32'h0,   0, 32'h110, 4'h0));
        vecs.push_back(mk(32'h100, 1, 32'h1000, 4'h9, 0, 32'h0,   0, 32'h104, 4'h3));
        vecs.push_back(mk(32'h100, 1, 32'h1000, 4'h9, 0, 32'h0,   0, 32'h104, 4'h6));
        vecs.push_back(mk(32'h100, 1, 32'h1000, 4'h9, 0, 32'h0,   0, 32'h104, 4'hC));
        vecs.push_back(mk(32'h100, 1, 32'h1000, 4'h9, 0, 32'h0,   0, 32'h104, 4'h8));
        vecs.push_back(mk(32'h100, 0, 32'h0,    4'h0, 0, 32'h0,   1, 32'h200, 4'h0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(32'h100, 1, 32'h114, 4'h5, 0, 32'h0, 1, 32'h200, 4'h0));
        vecs.push_back(mk(32'h100, 1, 32'h13C,  4'hE, 1, 32'h900, 1, 32'h200, 4'h0));
        vecs.push_back(mk(32'h100, 1, 32'h13C,  4'hE, 0, 32'h0,   0, 32'h104, 4'h1));
        vecs.push_back(mk(32'h100, 1, 32'h13C,  4'hE, 1, 32'h900, 0, 32'h104, 4'h2));
        vecs.push_back(mk(32'h100, 0, 32'h0,    4'h0, 0, 32'h0,   0, 32'h104, 4'h5));
        vecs.push_back(mk(32'h128, 1, 32'h128,  4'h5, 1, 32'h300, 0, 32'h12C, 4'hF));
        vecs.push_back(mk(32'h128, 1, 32'h128,  4'h5, 1, 32'h300, 0, 32'h12C, 4'h1));
        vecs.push_back(mk(32'h128, 1, 32'h128,  4'h5, 1, 32'h300, 0, 32'h12C, 4'hD));
        vecs.push_back(mk(32'h128, 1, 32'h128,  4'h5, 1, 32'h300, 1, 32'h300, 4'h5));
        vecs.push_back(mk(32'h128, 0, 32'h0,    4'h0, 0, 32'h0,   1, 32'h300, 4'h5));
        vecs.push_back(mk(32'h100, 1, 32'h500,  4'hF, 1, 32'h600, 0, 32'h104, 4'hF));
        vecs.push_back(mk(32'h100, 0, 32'h0,    4'h0, 0, 32'h0,   0, 32'h104, 4'hF));
        vecs.push_back(mk(32'h500, 0, 32'h0,    4'h0, 0, 32'h0,   1, 32'h600, 4'hF));
        vecs.push_back(mk(32'h104, 1, 32'h104,  4'hE, 1, 32'h700, 0, 32'h108, 4'hE));
        vecs.push_back(mk(32'h104, 0, 32'h0,    4'h0, 0, 32'h0,   1, 32'h700, 4'hE));

        for (int i = 0; i < vecs.size(); i++) begin
            bus.fe_pc      = vecs[i].pc;
            bus.upd_valid  = vecs[i].upd_v;
            bus.upd_pc     = vecs[i].upd_pc;
            bus.upd_idx    = vecs[i].upd_idx;
            bus.upd_taken  = vecs[i].upd_taken;
            bus.upd_target = vecs[i].upd_tgt;
            e.taken = vecs[i].exp_taken;
            e.tgt   = vecs[i].exp_tgt;
            e.idx   = vecs[i].exp_idx;
            sb_q.push_back(e);
            @(negedge clk);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL row%0d scoreboard empty", i);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("row%0d taken", i),  32'(bus.pred_taken), 32'(e.taken));
                check($sformatf("row%0d target", i), bus.pred_target, e.tgt);
                check($sformatf("row%0d idx", i),    32'(bus.pred_idx), 32'(e.idx));
            end
            next_cycle();
        end
        bus.upd_valid = 1'b0;
        @(negedge clk);
        check("final ready", 32'(bus.ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
